// File: rtl/cpu_dbg_pkg.sv
// cpu_dbg_pkg: shared types and constants for the CPU_Pipelined debug helpers.
//   WORD_W       data/address width
//   IDX_W        width of the scan word index
//   scan_state_e states of the data-memory scan FSM
//   word_addr()  byte address of word idx relative to a word-aligned base
package cpu_dbg_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned IDX_W  = 8;

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StWait,
      StEmit,
      StDone
   } scan_state_e;

   function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0] base,
                                                   input logic [IDX_W-1:0]  idx);
      return base + {{(WORD_W - IDX_W - 2){1'b0}}, idx, 2'b00};
   endfunction

endpackage

// File: rtl/dm_scan_checker_if.sv
// dm_scan_checker_if: data-memory read port plus the scanned-word output stream.
//   dm_rd_en / dm_rd_addr / dm_rd_data   read strobe, byte address, returned word
//   out_valid / out_ready                valid/ready handshake of the output stream
//   out_data / out_index                 scanned word and its index
// Modports: master = the scan checker, slave = data memory plus stream consumer.
interface dm_scan_checker_if;
   import cpu_dbg_pkg::*;

   logic              dm_rd_en;
   logic [WORD_W-1:0] dm_rd_addr;
   logic [WORD_W-1:0] dm_rd_data;
   logic              out_valid;
   logic              out_ready;
   logic [WORD_W-1:0] out_data;
   logic [IDX_W-1:0]  out_index;

   modport master (
      output dm_rd_en, dm_rd_addr, out_valid, out_data, out_index,
      input  dm_rd_data, out_ready
   );

   modport slave (
      input  dm_rd_en, dm_rd_addr, out_valid, out_data, out_index,
      output dm_rd_data, out_ready
   );

endinterface

// File: rtl/dm_scan_checker.sv
// dm_scan_checker: post-run data-memory reader. When pc equals HALT_PC it reads NUM_WORDS
// consecutive words starting at BASE_ADDR, streams each one out on a valid/ready port and
// reports whether the array is strictly ascending (signed).
// Ports:
//   clk        clock, all state on posedge
//   rst        synchronous active-high reset
//   pc         IF-stage PC value
//   bus        dm_scan_checker_if.master (memory read port + output stream)
//   done       scan finished, sticky until rst
//   sorted_ok  valid with done: 1 = strictly ascending
// Optional feature: define DM_SCAN_EARLY_ABORT_EN to finish on the first out-of-order word
// instead of streaming the whole array.
module dm_scan_checker
   import cpu_dbg_pkg::*;
#(
   parameter int unsigned BASE_ADDR  = 512,
   parameter int unsigned NUM_WORDS  = 12,
   parameter int unsigned HALT_PC    = 88,
   parameter int unsigned RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] pc,
   dm_scan_checker_if.master bus,
   output logic              done,
   output logic              sorted_ok
);

   if (NUM_WORDS < 1 || NUM_WORDS > 256) begin : g_bad_num_words
      $error("dm_scan_checker: NUM_WORDS must be 1..256");
   end
   if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_latency
      $error("dm_scan_checker: RD_LATENCY must be 1..3");
   end
   if (BASE_ADDR % 4 != 0) begin : g_bad_base
      $error("dm_scan_checker: BASE_ADDR must be word-aligned");
   end

   localparam logic [WORD_W-1:0] BASE     = WORD_W'(BASE_ADDR);
   localparam logic [WORD_W-1:0] HALT     = WORD_W'(HALT_PC);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);
   localparam logic [1:0]        LAT      = 2'(RD_LATENCY);

   scan_state_e       state_q;
   logic [IDX_W-1:0]  idx_q;
   logic [WORD_W-1:0] prev_q;
   logic              ok_q;
   logic [1:0]        lat_q;

   logic handshake;
   logic out_of_order;
   logic ok_next;
   logic finish;

   always_comb begin
      handshake    = bus.out_valid & bus.out_ready;
      // Word 0 has no predecessor; equal neighbours count as out of order.
      out_of_order = (idx_q != '0) && ($signed(bus.out_data) <= $signed(prev_q));
      ok_next      = ok_q & ~out_of_order;
`ifdef DM_SCAN_EARLY_ABORT_EN
      finish       = (idx_q == LAST_IDX) || out_of_order;
`else
      finish       = (idx_q == LAST_IDX);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StIdle;
         idx_q          <= '0;
         prev_q         <= '0;
         ok_q           <= 1'b1;
         lat_q          <= '0;
         bus.dm_rd_en   <= 1'b0;
         bus.dm_rd_addr <= '0;
         bus.out_valid  <= 1'b0;
         bus.out_data   <= '0;
         bus.out_index  <= '0;
         done           <= 1'b0;
         sorted_ok      <= 1'b0;
      end else begin
         // Read strobe is a single-cycle pulse, raised only on entry to StRead.
         bus.dm_rd_en <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (pc == HALT) begin
                  state_q        <= StRead;
                  bus.dm_rd_en   <= 1'b1;
                  bus.dm_rd_addr <= word_addr(BASE, idx_q);
               end
            end
            StRead: begin
               state_q <= StWait;
               lat_q   <= 2'd1;
            end
            StWait: begin
               if (lat_q == LAT) begin
                  state_q       <= StEmit;
                  bus.out_data  <= bus.dm_rd_data;
                  bus.out_index <= idx_q;
                  bus.out_valid <= 1'b1;
               end else begin
                  lat_q <= lat_q + 2'd1;
               end
            end
            StEmit: begin
               if (handshake) begin
                  bus.out_valid <= 1'b0;
                  ok_q          <= ok_next;
                  prev_q        <= bus.out_data;
                  if (finish) begin
                     state_q   <= StDone;
                     done      <= 1'b1;
                     sorted_ok <= ok_next;
                  end else begin
                     state_q        <= StRead;
                     idx_q          <= idx_q + IDX_W'(1);
                     bus.dm_rd_en   <= 1'b1;
                     bus.dm_rd_addr <= word_addr(BASE, idx_q + IDX_W'(1));
                  end
               end
            end
            StDone: ;
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
